// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 encodings and the condition-code register type.
// Holds the icode constants, the OPq and condition ifun constants, REG_NONE and cc_t.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;
endpackage

// File: rtl/y86_execute_pipe_cond.sv
// y86_cond_eval: combinational cmovXX/jXX condition evaluation.
// Ports: cc (condition codes), ifun (condition code) -> cnd (taken), bad (ifun not a legal condition).
module y86_cond_eval
    import y86_pkg::*;
(
    input  cc_t        cc,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       bad
);
    logic lt;

    assign lt  = cc.sf ^ cc.of;
    assign bad = ifun > C_G;

    always_comb begin
        cnd = ifun == C_ALWAYS ? 1'b1 :
              ifun == C_LE     ? lt | cc.zf :
              ifun == C_L      ? lt :
              ifun == C_E      ? cc.zf :
              ifun == C_NE     ? !cc.zf :
              ifun == C_GE     ? !lt :
              ifun == C_G      ? !lt && !cc.zf : 1'b0;
    end
endmodule

// File: rtl/y86_execute_pipe.sv
// y86_execute_pipe: pipelined Y86 execute stage with CC register and registered E/M slot.
// Inputs: clk, rst_n (async, active low), in_valid/in_ready handshake with decoded fields
//   in_icode/in_ifun/in_valA/in_valB/in_valC/in_dstE/in_dstM, set_cc gate, out_ready back-pressure.
// Outputs: out_valid and the E/M slot (out_icode/out_valE/out_valA/out_dstE/out_dstM/out_cnd/out_ins_err),
//   plus the live CC register zf/sf/of.
// Optional: define Y86_EXE_MUL_EN to add an iterative shift-add mulq (OPq ifun 4, XLEN+1 cycle latency).
module y86_execute_pipe
    import y86_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int STACK_STEP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_icode,
    input  logic [3:0]      in_ifun,
    input  logic [XLEN-1:0] in_valA,
    input  logic [XLEN-1:0] in_valB,
    input  logic [XLEN-1:0] in_valC,
    input  logic [3:0]      in_dstE,
    input  logic [3:0]      in_dstM,
    input  logic            set_cc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_icode,
    output logic [XLEN-1:0] out_valE,
    output logic [XLEN-1:0] out_valA,
    output logic [3:0]      out_dstE,
    output logic [3:0]      out_dstM,
    output logic            out_cnd,
    output logic            out_ins_err,
    output logic            zf,
    output logic            sf,
    output logic            of
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;
    localparam int         MSB  = XLEN - 1;

    cc_t             cc;
    logic [0:0]      state;
    logic            cnd_raw, cond_bad;
    logic            is_op, is_cond, is_mul, alu_ok, alu_of, ex_err;
    logic            slot_free, accept;
    logic [XLEN-1:0] alu_r, ex_valE;
    logic [3:0]      ex_dstE;
    cc_t             alu_cc;

    assign zf = cc.zf;
    assign sf = cc.sf;
    assign of = cc.of;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;

    // Conditions read the CC register as it stood before this edge, so an OPq is seen by the next instruction.
    y86_cond_eval u_cond (
        .cc  (cc),
        .ifun(in_ifun),
        .cnd (cnd_raw),
        .bad (cond_bad)
    );

    always_comb begin
        is_op   = in_icode == I_OPQ;
        is_cond = in_icode == I_RRMOVQ || in_icode == I_JXX;
`ifdef Y86_EXE_MUL_EN
        is_mul  = is_op && in_ifun == ALU_MUL;
`else
        is_mul  = 1'b0;
`endif
        alu_ok  = in_ifun <= ALU_XOR;
        alu_r   = in_ifun == ALU_ADD ? in_valB + in_valA :
                  in_ifun == ALU_SUB ? in_valB - in_valA :
                  in_ifun == ALU_AND ? in_valA & in_valB :
                  in_ifun == ALU_XOR ? in_valA ^ in_valB : '0;
        alu_of  = in_ifun == ALU_ADD ? (in_valA[MSB] == in_valB[MSB]) && (alu_r[MSB] != in_valA[MSB]) :
                  in_ifun == ALU_SUB ? (in_valA[MSB] != in_valB[MSB]) && (alu_r[MSB] != in_valB[MSB]) : 1'b0;
        alu_cc  = '{zf: alu_r == '0, sf: alu_r[MSB], of: alu_of};
        ex_err  = (is_op && !alu_ok && !is_mul) || (is_cond && cond_bad);
        ex_dstE = (in_icode == I_RRMOVQ && !cnd_raw) ? REG_NONE : in_dstE;
        ex_valE = in_icode == I_RRMOVQ                        ? in_valA :
                  in_icode == I_IRMOVQ                        ? in_valC :
                  (in_icode == I_RMMOVQ || in_icode == I_MRMOVQ) ? in_valB + in_valC :
                  (in_icode == I_CALL || in_icode == I_PUSHQ)    ? in_valB - XLEN'(STACK_STEP) :
                  (in_icode == I_RET || in_icode == I_POPQ)      ? in_valB + XLEN'(STACK_STEP) :
                  is_op                                          ? alu_r : '0;
    end

`ifdef Y86_EXE_MUL_EN
    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mcand, mplier, acc, m_valA, mul_step, mul_res;
    logic [3:0]      m_dstE, m_dstM;
    logic            m_set_cc, mul_done, mul_load;

    // cnt == XLEN marks a finished product parked until the slot frees.
    assign mul_step = mplier[0] ? mcand : '0;
    assign mul_res  = (cnt == CW'(XLEN)) ? acc : acc + mul_step;
    assign mul_done = (state == MUL) && (cnt >= CW'(XLEN - 1));
    assign mul_load = mul_done && slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            m_valA   <= '0;
            m_dstE   <= REG_NONE;
            m_dstM   <= REG_NONE;
            m_set_cc <= 1'b0;
        end else if (accept && is_mul) begin
            state    <= MUL;
            cnt      <= '0;
            mcand    <= in_valA;
            mplier   <= in_valB;
            acc      <= '0;
            m_valA   <= in_valA;
            m_dstE   <= in_dstE;
            m_dstM   <= in_dstM;
            m_set_cc <= set_cc;
        end else if (state == MUL) begin
            if (mul_load) begin
                state <= IDLE;
            end else if (cnt != CW'(XLEN)) begin
                acc    <= mul_res;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end
`else
    assign state = IDLE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_icode   <= 4'h0;
            out_valE    <= '0;
            out_valA    <= '0;
            out_dstE    <= REG_NONE;
            out_dstM    <= REG_NONE;
            out_cnd     <= 1'b0;
            out_ins_err <= 1'b0;
            cc          <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (accept && !is_mul) begin
            out_valid   <= 1'b1;
            out_icode   <= in_icode;
            out_valE    <= ex_valE;
            out_valA    <= in_valA;
            out_dstE    <= ex_dstE;
            out_dstM    <= in_dstM;
            out_cnd     <= is_cond && cnd_raw;
            out_ins_err <= ex_err;
            if (is_op && alu_ok && set_cc) cc <= alu_cc;
        end
`ifdef Y86_EXE_MUL_EN
        else if (mul_load) begin
            out_valid   <= 1'b1;
            out_icode   <= I_OPQ;
            out_valE    <= mul_res;
            out_valA    <= m_valA;
            out_dstE    <= m_dstE;
            out_dstM    <= m_dstM;
            out_cnd     <= 1'b0;
            out_ins_err <= 1'b0;
            if (m_set_cc) cc <= '{zf: mul_res == '0, sf: mul_res[MSB], of: 1'b0};
        end
`endif
        else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_y86_execute_pipe.sv
// tb_y86_execute_pipe: directed scenarios plus randomized traffic scored against a behavioural model.
module tb_y86_execute_pipe;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, set_cc = 1'b0;
    logic [3:0]  in_icode = '0, in_ifun = '0, in_dstE = 4'hF, in_dstM = 4'hF;
    logic [63:0] in_valA = '0, in_valB = '0, in_valC = '0;
    logic        out_valid, out_ready = 1'b1, out_cnd, out_ins_err, zf, sf, of;
    logic [3:0]  out_icode, out_dstE, out_dstM;
    logic [63:0] out_valE, out_valA;

    y86_execute_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_valA(in_valA), .in_valB(in_valB),
        .in_valC(in_valC), .in_dstE(in_dstE), .in_dstM(in_dstM), .set_cc(set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
        .out_valE(out_valE), .out_valA(out_valA), .out_dstE(out_dstE), .out_dstM(out_dstM),
        .out_cnd(out_cnd), .out_ins_err(out_ins_err), .zf(zf), .sf(sf), .of(of)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, wait_cycles = 0;
    logic rnd_on = 1'b0;
    logic mzf = 1'b1, msf = 1'b0, mof = 1'b0;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE, valA;
        logic [3:0]  dstE, dstM;
        logic        cnd, err, zf, sf, of;
    } exp_t;
    exp_t sbq[$];

    localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] SMIN = 65'sh1_8000_0000_0000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural reference: exact signed arithmetic decides overflow, conditions from the ISA table.
    function automatic exp_t ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                      input logic [3:0] de, input logic [3:0] dm, input logic sc);
        exp_t e;
        logic take, lt, ovf, legal;
        logic signed [64:0] s;
        logic [63:0] r;
        e.icode = ic; e.valA = a; e.dstE = de; e.dstM = dm;
        e.valE = '0; e.cnd = 1'b0; e.err = 1'b0;
        lt = msf != mof;
        take = 1'b0; ovf = 1'b0; legal = 1'b0; r = '0; s = '0;
        case (fn)
            4'd0: take = 1'b1;
            4'd1: take = lt || mzf;
            4'd2: take = lt;
            4'd3: take = mzf;
            4'd4: take = !mzf;
            4'd5: take = !lt;
            4'd6: take = !lt && !mzf;
            default: take = 1'b0;
        endcase
        if ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6) e.err = 1'b1;
        if (ic == 4'h2 || ic == 4'h7) e.cnd = take;
        case (ic)
            4'h2: begin e.valE = a; if (!take) e.dstE = 4'hF; end
            4'h3: e.valE = c;
            4'h4, 4'h5: e.valE = b + c;
            4'h8, 4'hA: e.valE = b - 64'd8;
            4'h9, 4'hB: e.valE = b + 64'd8;
            4'h6: begin
                legal = 1'b1;
                case (fn)
                    4'd0: begin s = $signed({b[63], b}) + $signed({a[63], a}); r = s[63:0]; ovf = s > SMAX || s < SMIN; end
                    4'd1: begin s = $signed({b[63], b}) - $signed({a[63], a}); r = s[63:0]; ovf = s > SMAX || s < SMIN; end
                    4'd2: r = a & b;
                    4'd3: r = a ^ b;
`ifdef Y86_EXE_MUL_EN
                    4'd4: r = a * b;
`endif
                    default: begin legal = 1'b0; e.err = 1'b1; end
                endcase
                e.valE = r;
                if (legal && sc) begin mzf = r == 0; msf = r[63]; mof = ovf; end
            end
            default: e.valE = '0;
        endcase
        e.zf = mzf; e.sf = msf; e.of = mof;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return 64'($urandom_range(0, 20));
            1: return {$urandom, $urandom};
            2: case ($urandom_range(0, 3))
                   0: return 64'h0;
                   1: return 64'h7FFF_FFFF_FFFF_FFFF;
                   2: return 64'h8000_0000_0000_0000;
                   default: return 64'hFFFF_FFFF_FFFF_FFFF;
               endcase
            default: return {32'h0, $urandom};
        endcase
    endfunction

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [3:0] de, input logic [3:0] dm,
                         input logic sc, input logic ordy);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_icode = ic; in_ifun = fn; in_valA = a; in_valB = b; in_valC = c;
        in_dstE = de; in_dstM = dm; set_cc = sc; out_ready = ordy;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) check("accept_timeout", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("result_timeout", {63'h0, out_valid}, 64'h1);
        wait_cycles = n;
    endtask

    always @(negedge clk) begin
        if (rnd_on && out_valid) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected", 64'(sbq.size()), 64'h1);
            end else begin
                check("icode", 64'(out_icode), 64'(sbq[0].icode));
                check("valE", out_valE, sbq[0].valE);
                check("valA", out_valA, sbq[0].valA);
                check("dstE", 64'(out_dstE), 64'(sbq[0].dstE));
                check("dstM", 64'(out_dstM), 64'(sbq[0].dstM));
                check("cnd", 64'(out_cnd), 64'(sbq[0].cnd));
                check("ins_err", 64'(out_ins_err), 64'(sbq[0].err));
                check("cc", {61'h0, zf, sf, of}, {61'h0, sbq[0].zf, sbq[0].sf, sbq[0].of});
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_cc", {61'h0, zf, sf, of}, 64'h4);
        check("rst_dstE", 64'(out_dstE), 64'hF);
        check("rst_dstM", 64'(out_dstM), 64'hF);
        check("rst_valE", out_valE, 64'h0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'h1);

        issue(I_OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h3, 4'hF, 1'b1, 1'b1);
        check("add_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_cc", {61'h0, zf, sf, of}, 64'h3);

        issue(I_OPQ, ALU_SUB, 64'd5, 64'd5, 0, 4'h3, 4'hF, 1'b1, 1'b1);
        check("sub_zf", 64'(zf), 64'h1);
        issue(I_JXX, C_NE, 0, 0, 64'h40, 4'hF, 4'hF, 1'b1, 1'b1);
        check("jne_cnd", 64'(out_cnd), 64'h0);
        issue(I_OPQ, ALU_ADD, 64'd1, 64'd1, 0, 4'h3, 4'hF, 1'b1, 1'b1);
        check("add2_zf", 64'(zf), 64'h0);
        issue(I_OPQ, ALU_SUB, 64'd5, 64'd5, 0, 4'h3, 4'hF, 1'b0, 1'b1);
        check("nocc_zf", 64'(zf), 64'h0);
        issue(I_JXX, C_NE, 0, 0, 64'h40, 4'hF, 4'hF, 1'b1, 1'b1);
        check("jne2_cnd", 64'(out_cnd), 64'h1);

        issue(I_OPQ, ALU_AND, 64'd1, 64'd3, 0, 4'h3, 4'hF, 1'b1, 1'b1);
        check("and_cc", {61'h0, zf, sf, of}, 64'h0);
        issue(I_RRMOVQ, C_L, 64'h55, 0, 0, 4'h3, 4'hF, 1'b1, 1'b1);
        check("cmov_cnd", 64'(out_cnd), 64'h0);
        check("cmov_dstE", 64'(out_dstE), 64'hF);
        check("cmov_valE", out_valE, 64'h55);

        issue(I_PUSHQ, 4'h0, 64'h77, 64'h100, 0, 4'h4, 4'hF, 1'b1, 1'b0);
        repeat (3) begin
            check("bp_in_ready", 64'(in_ready), 64'h0);
            check("bp_valE", out_valE, 64'hF8);
            check("bp_valid", 64'(out_valid), 64'h1);
            @(negedge clk);
        end
        issue(I_POPQ, 4'h0, 0, 64'h100, 0, 4'h4, 4'h5, 1'b1, 1'b1);
        check("pop_valE", out_valE, 64'h108);
        check("pop_dstM", 64'(out_dstM), 64'h5);

        issue(I_OPQ, ALU_MUL, 64'd7, 64'd6, 0, 4'h3, 4'hF, 1'b1, 1'b1);
`ifdef Y86_EXE_MUL_EN
        check("mul_wait", 64'(wait_cycles), 64'd64);
        check("mul_valE", out_valE, 64'd42);
        check("mul_err", 64'(out_ins_err), 64'h0);
        check("mul_zf_of", {62'h0, zf, of}, 64'h0);
`else
        check("mul_wait", 64'(wait_cycles), 64'd0);
        check("mul_err", 64'(out_ins_err), 64'h1);
        check("mul_valE", out_valE, 64'h0);
`endif
        issue(I_JXX, 4'h9, 0, 0, 64'h40, 4'hF, 4'hF, 1'b1, 1'b1);
        check("badj_err", 64'(out_ins_err), 64'h1);
        check("badj_cnd", 64'(out_cnd), 64'h0);

        issue(I_IRMOVQ, 4'h0, 0, 0, 64'h1234, 4'h2, 4'hF, 1'b1, 1'b0);
        check("irmov_valE", out_valE, 64'h1234);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(out_valid), 64'h0);
        check("mrst_cc", {61'h0, zf, sf, of}, 64'h4);
        check("mrst_valE", out_valE, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("mrst_in_ready", 64'(in_ready), 64'h1);
        mzf = 1'b1; msf = 1'b0; mof = 1'b0;

        rnd_on = 1'b1;
        repeat (600) begin
            logic [3:0] ic, fn;
            @(posedge clk);
            #1;
            in_valid  = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 7;
            ic = 4'($urandom_range(0, 11));
            fn = ic == I_OPQ ? 4'($urandom_range(0, 5)) :
                 (ic == I_RRMOVQ || ic == I_JXX) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
            in_icode = ic; in_ifun = fn;
            in_valA = rnd64(); in_valB = rnd64(); in_valC = rnd64();
            in_dstE = 4'($urandom_range(0, 15)); in_dstM = 4'($urandom_range(0, 15));
            set_cc = $urandom_range(0, 3) != 0;
            #1;
            if (in_valid && in_ready)
                sbq.push_back(ref_exec(in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, in_dstM, set_cc));
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 500 && sbq.size() > 0; n++) @(posedge clk);
        check("sb_drain", 64'(sbq.size()), 64'h0);
        rnd_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/y86_execute_pipe.md
Name: y86_execute_pipe

Overview:
- Parametrised, pipelined successor to the SEQ execute stage for the pipelined Y86 core.
- Accepts decoded operands over a valid/ready handshake and computes valE.
- Holds the condition codes (ZF/SF/OF) in an architectural register and evaluates cnd for cmovXX/jXX.
- Presents results in a registered E/M pipeline slot with back-pressure.

Parameters:
- XLEN, 64, datapath width in bits (legal: 16, 32, 64).
- STACK_STEP, 8, byte delta applied to %rsp for call/ret/pushq/popq.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode slot holds an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_valA  in  XLEN  operand A.
- in_valB  in  XLEN  operand B.
- in_valC  in  XLEN  immediate/displacement.
- in_dstE  in  4  E destination register id; 0xF means none.
- in_dstM  in  4  M destination register id.
- set_cc  in  1  CC update permitted; low when a downstream exception is pending.
- out_valid  out  1  E/M slot holds a result.
- out_ready  in  1  memory stage accepts the slot.
- out_icode  out  4  forwarded icode.
- out_valE  out  XLEN  execute result.
- out_valA  out  XLEN  forwarded valA.
- out_dstE  out  4  dstE, forced to 0xF when a cmov is not taken.
- out_dstM  out  4  forwarded dstM.
- out_cnd  out  1  condition outcome.
- out_ins_err  out  1  illegal OPq/cmov/jXX ifun.
- zf, sf, of  out  1 each  current CC register.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, every out_* data field=0 (out_dstE=out_dstM=0xF), zf=1, sf=0, of=0, FSM=IDLE.
  - Reset mid-multiply aborts the operation; no CC update occurs.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Non-multiply results appear with out_valid=1 the cycle after accept (latency 1).
- While out_valid=1 && out_ready=0, every out_* field holds stable.
- out_valid clears on out_ready when no new accept occurs in that cycle. Back-to-back accepts sustain 1 instruction/cycle.
- valE by icode:
  - cmovXX: valA.
  - irmovq: valC.
  - rmmovq/mrmovq: valB+valC.
  - call/pushq: valB-STACK_STEP.
  - ret/popq: valB+STACK_STEP.
  - OPq: ALU result.
  - All others: 0.
  - All arithmetic is modulo 2^XLEN.
- OPq ALU:
  - ifun 0 add: valB+valA.
  - ifun 1 sub: valB-valA.
  - ifun 2 and: valA&valB.
  - ifun 3 xor: valA^valB.
  - Any other ifun: out_ins_err=1, valE=0, CC unchanged.
- CC update happens on the accept edge of a legal OPq with set_cc=1:
  - ZF = (result==0).
  - SF = result[XLEN-1].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: valA and valB have different signs and the result sign differs from valB's.
  - OF for and/xor: 0.
- cnd is evaluated from the CC register value before the accepting edge. An OPq accepted in cycle N is therefore visible to a jXX/cmov accepted in cycle N+1.
- Conditions (ifun 0-6): always, le=(SF^OF)|ZF, l=SF^OF, e=ZF, ne=!ZF, ge=!(SF^OF), g=!(SF^OF)&!ZF.
  - ifun >6 on cmov/jXX: out_ins_err=1, cnd=0.
  - Non-conditional icodes: cnd=0.
  - cmov with cnd=0: out_dstE=0xF.
- FSM states: IDLE, MUL (only with multiply enabled).

Optional Feature:
- Macro: Y86_EXE_MUL_EN.
- Defined: OPq ifun 4 (mulq, low XLEN bits of valA*valB) is accepted.
  - IDLE goes to MUL; iterative shift-add over XLEN cycles; in_ready=0 throughout.
  - On the final cycle the result loads into the slot and the FSM returns to IDLE once the slot is free. Total latency XLEN+1 cycles from accept.
  - ZF/SF are set from the result, OF=0; set_cc is sampled at accept.
  - If out_valid && !out_ready at completion, the FSM remains in MUL holding the result until the slot frees.
- Undefined: ifun 4 is illegal (out_ins_err=1) and the FSM never leaves IDLE.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - ALU ifun constants (ALU_ADD..ALU_MUL).
  - condition ifun constants (C_ALWAYS..C_G).
  - REG_NONE=4'hF.
  - the cc_t struct {zf,sf,of}.
- One sub-module: y86_cond_eval (combinational cc_t plus ifun to cnd and illegal flag), shared later with branch prediction repair.

Test Plan:
- Reset: rst_n=0 asserted mid-stream -> out_valid=0, zf=1, sf=0, of=0, in_ready=1 after release.
- Add overflow: OPq add, valA=valB=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 -> valE=0xFFFF_FFFF_FFFF_FFFE, sf=1, of=1, zf=0.
- Compare and branch: subq valA=5, valB=5, then jne next cycle -> zf=1, out_cnd=0. Repeat with set_cc=0 -> CC unchanged from the prior value.
- Untaken cmov: cmovl after flags sf=0, of=0, in_dstE=3 -> out_cnd=0, out_dstE=0xF, valE=valA.
- Back-pressure: out_ready=0 for 3 cycles after pushq valB=0x100 -> in_ready=0, out_valE=0xF8 stable; after release, a follow-on popq yields 0x108.
- With Y86_EXE_MUL_EN: mulq valA=7, valB=6 -> in_ready low 64 cycles, valE=42, zf=0, of=0. Without the macro, the same stimulus gives out_ins_err=1, valE=0.
